// File: rtl/branch_pkg.sv
// branch_pkg: opcodes, FSM states and PHT counter helpers for branch_resolve_unit
package branch_pkg;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_BNE = 6'd5;
  localparam logic [5:0] OP_BLE = 6'd6;
  localparam logic [5:0] OP_BGT = 6'd7;
  localparam logic [5:0] OP_BLM = 6'd1;
  typedef enum logic [1:0] {IDLE, EVAL, WRITE} state_t;
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_INIT = 2'b01;
  function automatic ctr_t ctr_next(ctr_t c, logic t);
    return t ? (c == 2'd3 ? c : c + 2'd1) : (c == 2'd0 ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_cond.sv
// branch_cond: decodes branch opcode and comparator flags into taken/is_branch
// ports: opcode, igual/maior/menor in; taken, is_branch out (combinational)
module branch_cond
  import branch_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       igual,
  input  logic       maior,
  input  logic       menor,
  output logic       taken,
  output logic       is_branch
);
  always_comb begin
    is_branch = opcode inside {OP_BEQ, OP_BNE, OP_BLE, OP_BGT, OP_BLM};
    taken = opcode == OP_BEQ ? igual :
            opcode == OP_BNE ? !igual :
            opcode == OP_BLE ? !maior :
            opcode == OP_BGT ? maior :
            opcode == OP_BLM ? menor : 1'b0;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: 3-cycle branch resolver with 2-bit PHT predictor and stats
// ports: clk, reset_n; pred_req/pred_pc -> pred_valid/pred_taken;
//        res_valid/res_ready handshake with res_pc/opcode/flags/pred;
//        out_valid/out_taken/out_is_branch/out_mispredict; stat_clear, stat_branches/stat_mispred
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int PHT_DEPTH = 16,
  parameter int PC_W      = 32,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pred_req,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [PC_W-1:0]   res_pc,
  input  logic [5:0]        res_opcode,
  input  logic              res_igual,
  input  logic              res_maior,
  input  logic              res_menor,
  input  logic              res_pred,
  output logic              out_valid,
  output logic              out_taken,
  output logic              out_is_branch,
  output logic              out_mispredict,
  input  logic              stat_clear,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);
  localparam int IDX_W = $clog2(PHT_DEPTH);
  state_t           state;
  logic [IDX_W-1:0] l_idx;
  logic [5:0]       l_op;
  logic             l_ig;
  logic             l_ma;
  logic             l_me;
  logic             l_pred;
  logic             c_taken;
  logic             c_br;
  ctr_t             pht [PHT_DEPTH];
  ctr_t             upd;
  logic [IDX_W-1:0] p_idx;
  logic             bypass;
  logic             unused;
  branch_cond u_cond (
    .opcode    (l_op),
    .igual     (l_ig),
    .maior     (l_ma),
    .menor     (l_me),
    .taken     (c_taken),
    .is_branch (c_br)
  );
  assign res_ready = state == IDLE;
  assign unused = ^{pred_pc, res_pc};
  always_comb begin
    p_idx = pred_pc[IDX_W+1:2];
    bypass = state == WRITE && out_is_branch && p_idx == l_idx;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      l_idx <= '0;
      l_op <= '0;
      l_ig <= 1'b0;
      l_ma <= 1'b0;
      l_me <= 1'b0;
      l_pred <= 1'b0;
      upd <= CTR_INIT;
      out_valid <= 1'b0;
      out_taken <= 1'b0;
      out_is_branch <= 1'b0;
      out_mispredict <= 1'b0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      stat_branches <= '0;
      stat_mispred <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= CTR_INIT;
    end else begin
      pred_valid <= pred_req;
      if (pred_req) pred_taken <= bypass ? upd[1] : pht[p_idx][1];
      if (state == IDLE) begin
        if (res_valid) begin
          l_idx <= res_pc[IDX_W+1:2];
          l_op <= res_opcode;
          l_ig <= res_igual;
          l_ma <= res_maior;
          l_me <= res_menor;
          l_pred <= res_pred;
          state <= EVAL;
        end
      end else if (state == EVAL) begin
        out_taken <= c_taken;
        out_is_branch <= c_br;
        out_mispredict <= c_br && (c_taken != l_pred);
        upd <= ctr_next(pht[l_idx], c_taken);
        out_valid <= 1'b1;
        state <= WRITE;
      end else begin
        out_valid <= 1'b0;
        if (out_is_branch) pht[l_idx] <= upd;
        state <= IDLE;
      end
      if (stat_clear) begin
        stat_branches <= '0;
        stat_mispred <= '0;
      end else if (state == WRITE && out_is_branch) begin
        if (!(&stat_branches)) stat_branches <= stat_branches + STAT_W'(1);
        if (out_mispredict && !(&stat_mispred)) stat_mispred <= stat_mispred + STAT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: randomized scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
  localparam int PD = 16;
  localparam int PW = 32;
  localparam int SW = 2;
  localparam int SMAX = (1 << SW) - 1;
  logic clk = 0;
  logic reset_n = 0;
  logic pred_req = 0;
  logic [PW-1:0] pred_pc = 0;
  logic pred_valid, pred_taken;
  logic res_valid = 0;
  logic res_ready;
  logic [PW-1:0] res_pc = 0;
  logic [5:0] res_opcode = 0;
  logic res_igual = 0, res_maior = 0, res_menor = 0, res_pred = 0;
  logic out_valid, out_taken, out_is_branch, out_mispredict;
  logic stat_clear = 0;
  logic [SW-1:0] stat_branches, stat_mispred;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PHT_DEPTH(PD), .PC_W(PW), .STAT_W(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc), .res_opcode(res_opcode),
    .res_igual(res_igual), .res_maior(res_maior), .res_menor(res_menor), .res_pred(res_pred),
    .out_valid(out_valid), .out_taken(out_taken), .out_is_branch(out_is_branch),
    .out_mispredict(out_mispredict), .stat_clear(stat_clear),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  typedef struct packed {logic taken; logic br; logic mis;} exp_t;
  exp_t q[$];
  logic pq[$];
  int errors = 0;
  int checks = 0;
  int pht_m[PD];
  int sb_m, sm_m;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % PD);
  endfunction

  function automatic logic is_br(logic [5:0] op);
    return op == 1 || (op >= 4 && op <= 7);
  endfunction

  function automatic logic cond(logic [5:0] op, logic ig, logic ma, logic me);
    case (op)
      6'd4: return ig;
      6'd5: return !ig;
      6'd6: return !ma;
      6'd7: return ma;
      6'd1: return me;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PD; i++) pht_m[i] = 1;
    sb_m = 0;
    sm_m = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic p;
    if (reset_n) begin
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_taken", out_taken, e.taken);
          chk("out_is_branch", out_is_branch, e.br);
          chk("out_mispredict", out_mispredict, e.mis);
        end
      end
      if (pred_valid) begin
        if (pq.size() == 0) chk("unexpected_pred_valid", 1, 0);
        else begin
          p = pq.pop_front();
          chk("pred_taken", pred_taken, p);
        end
      end
    end
  end

  task automatic resolve(logic [31:0] pc, logic [5:0] op, logic ig, logic ma, logic me,
                         logic pr, bit drop = 0);
    int n;
    logic t, b, m;
    @(negedge clk);
    res_pc = pc; res_opcode = op; res_igual = ig; res_maior = ma; res_menor = me;
    res_pred = pr; res_valid = 1;
    n = 0;
    while (!res_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("res_ready_timeout", 0, 1);
    @(posedge clk);
    if (drop) begin
      #2 reset_n = 0;
      #2 reset_n = 1;
      model_reset();
    end else begin
      t = cond(op, ig, ma, me);
      b = is_br(op);
      m = b && (t != pr);
      q.push_back('{taken: t, br: b, mis: m});
      if (b) begin
        pht_m[idx_of(pc)] = t ? (pht_m[idx_of(pc)] == 3 ? 3 : pht_m[idx_of(pc)] + 1)
                              : (pht_m[idx_of(pc)] == 0 ? 0 : pht_m[idx_of(pc)] - 1);
        sb_m = sb_m == SMAX ? SMAX : sb_m + 1;
        if (m) sm_m = sm_m == SMAX ? SMAX : sm_m + 1;
      end
    end
    @(negedge clk);
    res_valid = 0;
  endtask

  task automatic predict(logic [31:0] pc);
    @(negedge clk);
    pred_req = 1;
    pred_pc = pc;
    pq.push_back(pht_m[idx_of(pc)] >= 2);
    @(negedge clk);
    pred_req = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_stats(string tag);
    wait_idle();
    chk({tag, "_stat_branches"}, stat_branches, sb_m);
    chk({tag, "_stat_mispred"}, stat_mispred, sm_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [6];
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
    chk("reset_res_ready", res_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_pred_valid", pred_valid, 0);
    check_stats("reset");
    predict(32'h40);

    resolve(32'h40, 6'd4, 1, 0, 0, 0);
    chk("lat_eval_out_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_write_out_valid", out_valid, 1);
    @(negedge clk);
    chk("lat_after_out_valid", out_valid, 0);
    chk("hold_out_taken", out_taken, 1);
    check_stats("beq");
    predict(32'h40);

    resolve(32'h80, 6'd5, 0, 0, 0, 1);
    resolve(32'h84, 6'd6, 0, 1, 0, 1);
    resolve(32'h88, 6'd7, 0, 1, 0, 0);
    resolve(32'h8c, 6'd1, 0, 0, 1, 1);
    check_stats("sweep");
    stat_clear = 1;
    @(negedge clk);
    stat_clear = 0;
    sb_m = 0; sm_m = 0;
    resolve(32'h90, 6'h23, 1, 1, 1, 1);
    check_stats("nonbranch");

    for (int i = 0; i < 4; i++) resolve(32'h44, 6'd4, 1, 0, 0, 1);
    wait_idle();
    predict(32'h44);
    for (int i = 0; i < 5; i++) resolve(32'h44, 6'd4, 0, 0, 0, 0);
    wait_idle();
    predict(32'h44);
    check_stats("saturate");

    resolve(32'h44, 6'd4, 1, 0, 0, 0);
    wait_idle();
    resolve(32'h44, 6'd4, 1, 0, 0, 0);
    predict(32'h44);
    wait_idle();

    resolve(32'h50, 6'd4, 1, 0, 0, 0);
    @(negedge clk);
    stat_clear = 1;
    @(negedge clk);
    stat_clear = 0;
    sb_m = 0; sm_m = 0;
    check_stats("clear_priority");

    for (int i = 0; i < 150; i++) begin
      ops = '{6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'($urandom_range(0, 63))};
      resolve($urandom & 32'hFC, ops[$urandom_range(0, 5)], 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        predict($urandom & 32'hFC);
      end
      if ($urandom_range(0, 15) == 0) begin
        check_stats("rand");
        @(negedge clk);
        stat_clear = 1;
        @(negedge clk);
        stat_clear = 0;
        sb_m = 0; sm_m = 0;
      end
    end
    check_stats("rand_end");

    resolve(32'h40, 6'd4, 1, 0, 0, 0);
    wait_idle();
    resolve(32'h40, 6'd4, 1, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("rst_res_ready", res_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    check_stats("rst");
    predict(32'h40);
    wait_idle();
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    chk("pred_queue_empty", pq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and prediction block for the multicycle MIPS datapath. It evaluates the branch condition from the ALU comparator flags (Igual/Maior/Menor) for beq/bne/ble/bgt/blm through a valid/ready handshake. It also keeps a pattern history table of 2-bit saturating counters indexed by PC, and serves registered taken/not-taken predictions to fetch. Saturating statistics counters report resolved branches and mispredictions.

## Interface
Parameters:
- PHT_DEPTH, 16: number of 2-bit counters; power of two, ≥2; IDX_W = $clog2(PHT_DEPTH).
- PC_W, 32: PC width; PC_W ≥ IDX_W+2.
- STAT_W, 16: width of statistics counters.

Ports:
- clk  in  1  single clock; everything is sampled on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pred_req  in  1  prediction lookup request.
- pred_pc  in  PC_W  PC of the instruction being looked up.
- pred_valid  out  1  prediction result valid; one cycle after pred_req.
- pred_taken  out  1  MSB of the PHT counter at the looked-up index.
- res_valid  in  1  resolve request valid.
- res_ready  out  1  block can accept a resolve request.
- res_pc  in  PC_W  PC of the branch being resolved.
- res_opcode  in  6  instruction opcode.
- res_igual, res_maior, res_menor  in  1 each  comparator flags.
- res_pred  in  1  prediction fetch used for this branch.
- out_valid  out  1  one-cycle pulse: result fields are valid.
- out_taken  out  1  resolved branch decision.
- out_is_branch  out  1  opcode is one of the five branch opcodes.
- out_mispredict  out  1  out_is_branch && (out_taken != latched res_pred).
- stat_clear  in  1  synchronous clear of both statistics counters.
- stat_branches  out  STAT_W  resolved-branch count.
- stat_mispred  out  STAT_W  misprediction count.

## Operation
- Condition rules:
  - opcode 4 (beq): taken = igual.
  - opcode 5 (bne): taken = !igual.
  - opcode 6 (ble): taken = !maior.
  - opcode 7 (bgt): taken = maior.
  - opcode 1 (blm): taken = menor.
  - Any other opcode: taken = 0, is_branch = 0.
- PHT index is pc[IDX_W+1:2]. Each entry is a 2-bit saturating counter; it increments on taken and decrements on not taken, saturating at 3 and 0.
- FSM states:
  - IDLE: res_ready=1. On res_valid, latch pc, opcode, flags and pred, then go to EVAL.
  - EVAL: res_ready=0. Compute taken/is_branch from the latched inputs and read the PHT entry, then go to WRITE.
  - WRITE: res_ready=0. Assert out_valid for exactly one cycle. If is_branch, write the updated counter at the clock edge ending WRITE. Return to IDLE.
- Non-branch opcodes complete the full IDLE→EVAL→WRITE sequence. They leave the PHT and statistics untouched, and force out_mispredict=0.
- Statistics update at the edge ending WRITE:
  - stat_branches increments when is_branch.
  - stat_mispred increments when the result is a misprediction.
  - Both saturate at all-ones and never wrap.
- stat_clear has priority over a same-cycle increment.
- The prediction port is independent of the FSM and is accepted every cycle; there is no backpressure.

## Timing
- Reset values:
  - FSM = IDLE, so res_ready=1.
  - out_valid=0, out_taken=0, out_is_branch=0, out_mispredict=0.
  - pred_valid=0, pred_taken=0.
  - stat_branches=0, stat_mispred=0.
  - Every PHT entry = 2'b01 (weakly not taken).
- Resolve latency: request accepted at edge N produces out_valid high in cycle N+2. Throughput is one resolve per 3 cycles.
- Out fields hold their value after out_valid drops, until the next WRITE.
- Prediction latency is 1 cycle: pred_req at edge N gives pred_valid/pred_taken in cycle N+1. pred_taken holds when pred_req=0; pred_valid=0 in that case.
- Same-index hazard: a pred_req in the WRITE cycle to the index being written returns the new counter MSB (write-first bypass).
- reset_n asserted mid-operation immediately returns the FSM to IDLE. Any in-flight resolve is dropped with no PHT or statistics update, and out_valid is forced low.
- res_valid in EVAL or WRITE is ignored. The requester must hold its request until res_ready.

## Structure
- Package branch_pkg holds:
  - Opcode constants OP_BEQ=6'd4, OP_BNE=6'd5, OP_BLE=6'd6, OP_BGT=6'd7, OP_BLM=6'd1.
  - FSM state enum: IDLE, EVAL, WRITE.
  - 2-bit counter typedef and constant CTR_INIT=2'b01.
- One combinational sub-module, branch_cond: opcode plus flags in; taken and is_branch out.
- The PHT is a flop array, not inferred RAM, because it needs reset and bypass.

## Test plan
- After reset: res_ready=1, stats=0, and pred_req at PC 0x40 gives pred_taken=0 one cycle later.
- beq at PC 0x40, igual=1, res_pred=0: out_valid 2 cycles after accept with taken=1, mispredict=1; stat_mispred=1; PHT[0] goes to 2, so the next predict at 0x40 gives taken=1.
- Opcode sweep:
  - bne, igual=0 → taken=1.
  - ble, maior=1 → taken=0.
  - bgt, maior=1 → taken=1.
  - blm, menor=1 → taken=1.
  - Opcode 0x23 → is_branch=0, no stat change.
- Saturation: 4 taken beq at 0x44 → counter 3. Then 5 not-taken → counter 0 and a prediction of 0. With STAT_W=2, stat_branches sticks at 3.
- Bypass: pred_req at 0x44 issued during the WRITE cycle of a resolve at 0x44 returns the updated MSB.
- reset_n pulsed while in EVAL: no out_valid, the PHT entry is unchanged, and res_ready=1 after reset.
